nanomamba_mel_fbank: RTL



---
 rtl/nanomamba_mel_fbank_if.sv | 36 +++
 rtl/nanomamba_mel_fbank.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/nanomamba_mel_fbank_if.sv
// rtl/nanomamba_mel_fbank_if.sv - bin input, weight write and mel output signals of the mel filterbank
interface nanomamba_mel_fbank_if;
    logic [15:0] pwr_in;
    logic        pwr_valid;
    logic        pwr_last;
    logic        pwr_ready;
    logic        wt_we;
    logic [7:0]  wt_addr;
    logic [13:0] wt_data;
    logic        dst_ready;
    logic [15:0] mel_out;
    logic [5:0]  mel_index;
    logic        mel_valid;
    logic        mel_frame_done;
`ifdef MEL_FBANK_SAT_CNT_EN
    logic [7:0]  sat_count;

    modport slave (
        input  pwr_in, pwr_valid, pwr_last, wt_we, wt_addr, wt_data, dst_ready,
        output pwr_ready, mel_out, mel_index, mel_valid, mel_frame_done, sat_count
    );
    modport master (
        output pwr_in, pwr_valid, pwr_last, wt_we, wt_addr, wt_data, dst_ready,
        input  pwr_ready, mel_out, mel_index, mel_valid, mel_frame_done, sat_count
    );
`else
    modport slave (
        input  pwr_in, pwr_valid, pwr_last, wt_we, wt_addr, wt_data, dst_ready,
        output pwr_ready, mel_out, mel_index, mel_valid, mel_frame_done
    );
    modport master (
        output pwr_in, pwr_valid, pwr_last, wt_we, wt_addr, wt_data, dst_ready,
        input  pwr_ready, mel_out, mel_index, mel_valid, mel_frame_done
    );
`endif
endinterface

// File: rtl/nanomamba_mel_fbank.sv
// rtl/nanomamba_mel_fbank.sv - streaming triangular mel filterbank with per-frame drain
// Optional saturated-band counter output: define MEL_FBANK_SAT_CNT_EN.
module nanomamba_mel_fbank #(
    parameter int N_MELS    = 40,
    parameter int N_BINS    = 129,
    parameter int ACC_W     = 32,
    parameter int OUT_SHIFT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nanomamba_mel_fbank_if.slave  bus
);
    typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_DONE} state_t;

    localparam logic [8:0] BINS9   = 9'(N_BINS);
    localparam logic [6:0] MELS7   = 7'(N_MELS);
    localparam logic [5:0] LAST_CH = 6'(N_MELS - 1);
    // Entries are stored XOR this pattern so all-zero storage reads as {lo=63, w=0}.
    localparam logic [13:0] WT_DEFAULT = 14'h3F00;

    state_t           r_state;
    logic [13:0]      r_wt [N_BINS];
    logic [8:0]       r_bin_cnt;
    logic [5:0]       r_ch;
    logic [ACC_W-1:0] r_acc [N_MELS];
    logic             r_pwr_ready;
    logic [15:0]      r_mel_out;
    logic [5:0]       r_mel_index;
    logic             r_mel_valid;
    logic             r_frame_done;

    logic             w_accept, w_contrib, w_emit, w_lo_ok, w_hi_ok, w_sat;
    logic [13:0]      w_entry;
    logic [5:0]       w_lo, w_hi;
    logic [7:0]       w_w;
    logic [23:0]      w_p_lo, w_p_hi;
    logic [ACC_W-1:0] w_acc_sh;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [23:0] p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(p);
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    assign w_accept  = r_pwr_ready && bus.pwr_valid;
    assign w_contrib = w_accept && (r_bin_cnt < BINS9);
    assign w_emit    = (r_state == S_DRAIN) && bus.dst_ready;
    assign w_entry   = (r_bin_cnt < BINS9) ? (r_wt[r_bin_cnt[7:0]] ^ WT_DEFAULT) : WT_DEFAULT;
    assign w_lo      = w_entry[13:8];
    assign w_w       = w_entry[7:0];
    assign w_hi      = w_lo + 6'd1;
    assign w_lo_ok   = w_contrib && ({1'b0, w_lo} < MELS7);
    assign w_hi_ok   = w_contrib && ({1'b0, w_hi} < MELS7);
    assign w_p_lo    = 24'(w_w) * 24'(bus.pwr_in);
    assign w_p_hi    = 24'(9'd256 - {1'b0, w_w}) * 24'(bus.pwr_in);
    assign w_acc_sh  = r_acc[r_ch] >> OUT_SHIFT;
    assign w_sat     = |w_acc_sh[ACC_W-1:16];

    always_ff @(posedge clk) begin
        if (bus.wt_we && ({1'b0, bus.wt_addr} < BINS9))
            r_wt[bus.wt_addr] <= bus.wt_data ^ WT_DEFAULT;
    end

    // lo and lo+1 never coincide, so each band sees at most one product per bin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < N_MELS; m++) r_acc[m] <= '0;
        end else begin
            for (int m = 0; m < N_MELS; m++) begin
                if (w_lo_ok && w_lo == 6'(m))
                    r_acc[m] <= sat_add(r_acc[m], w_p_lo);
                else if (w_hi_ok && w_hi == 6'(m))
                    r_acc[m] <= sat_add(r_acc[m], w_p_hi);
                else if (w_emit && r_ch == 6'(m))
                    r_acc[m] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_ACCUM;
            r_pwr_ready  <= 1'b0;
            r_bin_cnt    <= '0;
            r_ch         <= '0;
            r_mel_out    <= '0;
            r_mel_index  <= '0;
            r_mel_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_mel_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_ACCUM: begin
                    r_pwr_ready <= 1'b1;
                    if (w_accept) begin
                        if (r_bin_cnt < BINS9) r_bin_cnt <= r_bin_cnt + 9'd1;
                        if (bus.pwr_last) begin
                            r_state     <= S_DRAIN;
                            r_ch        <= '0;
                            r_pwr_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.dst_ready) begin
                        r_mel_out   <= w_sat ? 16'hFFFF : w_acc_sh[15:0];
                        r_mel_index <= r_ch;
                        r_mel_valid <= 1'b1;
                        r_ch        <= r_ch + 6'd1;
                        if (r_ch == LAST_CH) r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_frame_done <= 1'b1;
                    r_bin_cnt    <= '0;
                    r_state      <= S_ACCUM;
                    r_pwr_ready  <= 1'b1;
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

`ifdef MEL_FBANK_SAT_CNT_EN
    logic [7:0] r_sat_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat_cnt <= '0;
        else if (w_accept && bus.pwr_last)
            r_sat_cnt <= '0;
        else if (w_emit && w_sat)
            r_sat_cnt <= r_sat_cnt + 8'd1;
    end
    assign bus.sat_count = r_sat_cnt;
`endif

    assign bus.pwr_ready      = r_pwr_ready;
    assign bus.mel_out        = r_mel_out;
    assign bus.mel_index      = r_mel_index;
    assign bus.mel_valid      = r_mel_valid;
    assign bus.mel_frame_done = r_frame_done;
endmodule
